stream_rr_arb: RTL and testbench

STREAM_RR_ARB -- requirements
Module: stream_rr_arb

---
 rtl/stream_arb_pkg.sv | 9 +
 rtl/pipeline_reg.sv | 24 ++
 rtl/rr_pick.sv | 20 ++
 rtl/stream_rr_arb.sv | 63 ++++++
 tb/tb_stream_rr_arb.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared defaults, arbiter state and source-width helper for stream_rr_arb
package stream_arb_pkg;
   localparam int N_REQ_DEF = 4;
   localparam int DATA_W_DEF = 32;
   typedef enum logic {IDLE, LOCKED} arb_state_t;
   function automatic int src_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pipeline_reg.sv
// pipeline_reg: single-entry valid/ready register slice, full throughput with same-cycle drain and refill
module pipeline_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   assign in_ready = ~out_valid | out_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data <= in_data;
      end else if (out_ready)
         out_valid <= 1'b0;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request after last_grant, with wrap-around
module rr_pick #(
   parameter int N = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] idx
);
   always_comb begin
      grant = '0;
      idx = '0;
      for (int k = N; k >= 1; k--)
         if (req[(int'(last_grant) + k) % N]) begin
            grant = N'(1) << ((int'(last_grant) + k) % N);
            idx = SW'((int'(last_grant) + k) % N);
         end
   end
endmodule

// File: rtl/stream_rr_arb.sv
// stream_rr_arb: packet-aware round-robin arbiter of N_REQ valid/ready streams into one registered output
module stream_rr_arb import stream_arb_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          in_valid,
   output logic [N_REQ-1:0]          in_ready,
   input  logic [N_REQ*DATA_W-1:0]   in_data,
   input  logic [N_REQ-1:0]          in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [src_w(N_REQ)-1:0]   out_src,
   output logic                      out_last
);
   localparam int SRC_W = src_w(N_REQ);
   localparam int STG_W = DATA_W + SRC_W + 1;
   arb_state_t state, state_nx;
   logic [SRC_W-1:0] last_grant, lock_src, pick_idx, sel;
   logic [N_REQ-1:0] pick_grant, grant;
   logic stage_ready, accept, sel_last;
   logic [DATA_W-1:0] sel_data;
   logic [STG_W-1:0] stage_q;
   rr_pick #(.N(N_REQ), .SW(SRC_W)) u_pick (
      .req(in_valid),
      .last_grant(last_grant),
      .grant(pick_grant),
      .idx(pick_idx)
   );
   always_comb begin
      sel = (state == LOCKED) ? lock_src : pick_idx;
      grant = (state == LOCKED) ? N_REQ'(1) << lock_src : pick_grant;
      in_ready = (rst_n && stage_ready) ? grant : '0;
      sel_data = in_data[int'(sel)*DATA_W +: DATA_W];
      sel_last = in_last[sel];
      accept = |(in_valid & in_ready);
      state_nx = accept ? (sel_last ? IDLE : LOCKED) : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last_grant <= SRC_W'(N_REQ - 1);
         lock_src <= '0;
      end else if (accept) begin
         lock_src <= sel;
         if (sel_last) last_grant <= sel;
      end
   pipeline_reg #(.W(STG_W)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(accept),
      .in_ready(stage_ready),
      .in_data({sel_data, sel, sel_last}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(stage_q)
   );
   assign {out_data, out_src, out_last} = stage_q;
endmodule

// File: tb/tb_stream_rr_arb.sv
// tb_stream_rr_arb: vector table, directed packet sequences and randomized run against a transaction model
module tb_stream_rr_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] v4 = 4'hF, l4 = 4'hF, r4;
   logic or4 = 1'b1;
   logic [127:0] d4 = '0;
   logic ov4, ol4;
   logic [31:0] od4;
   logic [1:0] os4;

   logic [1:0] v2 = 2'b00, l2 = 2'b11, r2;
   logic or2 = 1'b1;
   logic [63:0] d2 = '0;
   logic ov2, ol2;
   logic [31:0] od2;
   logic os2;

   stream_rr_arb #(.N_REQ(4), .DATA_W(32)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_src(os4), .out_last(ol4)
   );
   stream_rr_arb #(.N_REQ(2), .DATA_W(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(d2), .in_last(l2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_src(os2), .out_last(ol2)
   );

   int passed = 0, total = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   int m_lg, m_ls, m_os;
   bit m_lock, m_ov, m_ol;
   logic [31:0] m_od;
   function automatic void m_reset();
      m_lg = 3; m_lock = 0; m_ls = 0; m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
   endfunction
   function automatic int m_pick(input logic [3:0] v);
      if (m_lock) return m_ls;
      for (int k = 1; k <= 4; k++)
         if (v[(m_lg + k) % 4]) return (m_lg + k) % 4;
      return -1;
   endfunction

   logic [3:0] obs_r4;
   logic [1:0] obs_r2;
   logic obs_ov, obs_ol, obs_os2;
   logic [1:0] obs_os;
   logic [31:0] obs_od;

   task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                        input logic [127:0] d, input logic [1:0] v2i, input string nm);
      int g;
      logic sr;
      logic [3:0] er;
      v4 = v; l4 = l; or4 = ordy; d4 = d; v2 = v2i;
      @(negedge clk);
      g = m_pick(v);
      sr = !m_ov || ordy;
      er = (g >= 0 && sr) ? 4'(1 << g) : 4'b0;
      obs_r4 = r4; obs_ov = ov4; obs_os = os4; obs_od = od4; obs_ol = ol4;
      obs_r2 = r2; obs_os2 = os2;
      chk({nm, " in_ready"}, 64'(r4), 64'(er));
      chk({nm, " out_valid"}, 64'(ov4), 64'(m_ov));
      if (m_ov) begin
         chk({nm, " out_src"}, 64'(os4), 64'(m_os));
         chk({nm, " out_data"}, 64'(od4), 64'(m_od));
         chk({nm, " out_last"}, 64'(ol4), 64'(m_ol));
      end
      @(posedge clk);
      if (g >= 0 && sr && v[g]) begin
         m_ov = 1; m_od = d[g*32 +: 32]; m_os = g; m_ol = l[g];
         m_lock = !l[g]; m_ls = g;
         if (l[g]) m_lg = g;
      end else if (ordy) m_ov = 0;
      #1;
   endtask

   task automatic do_reset();
      v4 = '0; v2 = '0; rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] v, l;
      logic ordy;
      logic [3:0] rdy;
      logic ov;
      int src;
   } vec_t;
   vec_t tbl[5];
   logic [127:0] dseq;

   initial begin
      m_reset();
      #2;
      chk("reset out_valid", 64'(ov4), 0);
      chk("reset out_data", 64'(od4), 0);
      chk("reset out_src", 64'(os4), 0);
      chk("reset out_last", 64'(ol4), 0);
      chk("reset in_ready", 64'(r4), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b0, 0};
      tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 0};
      tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 1};
      tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2};
      tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 3};
      dseq = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      for (int i = 0; i < 5; i++) begin
         cycle(tbl[i].v, tbl[i].l, tbl[i].ordy, dseq, 2'b00, "rr");
         chk("rr tbl in_ready", 64'(obs_r4), 64'(tbl[i].rdy));
         chk("rr tbl out_valid", 64'(obs_ov), 64'(tbl[i].ov));
         if (tbl[i].ov) begin
            chk("rr tbl out_src", 64'(obs_os), 64'(tbl[i].src));
            chk("rr tbl out_data", 64'(obs_od), 64'(32'h1000_0000 + tbl[i].src));
         end
      end

      do_reset();
      cycle(4'b0010, 4'b0010, 1, dseq, 0, "pkt");
      cycle(4'b0110, 4'b0000, 1, dseq, 0, "pkt");
      cycle(4'b0110, 4'b0000, 1, dseq, 0, "pkt");
      chk("pkt beat1 src", 64'(obs_os), 2);
      cycle(4'b0110, 4'b0100, 1, dseq, 0, "pkt");
      chk("pkt beat2 src", 64'(obs_os), 2);
      cycle(4'b0010, 4'b0010, 1, dseq, 0, "pkt");
      chk("pkt beat3 src", 64'(obs_os), 2);
      chk("pkt beat3 last", 64'(obs_ol), 1);
      cycle(4'b0000, 4'b0000, 1, dseq, 0, "pkt");
      chk("pkt next src", 64'(obs_os), 1);

      do_reset();
      cycle(4'b0010, 4'b0010, 1, dseq, 0, "drop");
      cycle(4'b0101, 4'b0000, 1, dseq, 0, "drop");
      chk("drop lock rdy", 64'(obs_r4), 4'b0100);
      cycle(4'b0001, 4'b0001, 1, dseq, 0, "drop");
      chk("drop hold1 rdy", 64'(obs_r4), 4'b0100);
      cycle(4'b0001, 4'b0001, 1, dseq, 0, "drop");
      chk("drop hold2 rdy", 64'(obs_r4), 4'b0100);
      chk("drop gap valid", 64'(obs_ov), 0);
      cycle(4'b0101, 4'b0100, 1, dseq, 0, "drop");
      cycle(4'b0001, 4'b0001, 1, dseq, 0, "drop");
      chk("drop resume rdy", 64'(obs_r4), 4'b0001);
      chk("drop end src", 64'(obs_os), 2);
      cycle(4'b0000, 4'b0000, 1, dseq, 0, "drop");
      chk("drop then src", 64'(obs_os), 0);

      do_reset();
      cycle(4'b0001, 4'b0001, 1, {96'h0, 32'hA5A5A5A5}, 0, "stall");
      for (int i = 0; i < 5; i++) begin
         cycle(4'b0001, 4'b0001, 0, {96'h0, 32'h11111111}, 0, "stall");
         chk("stall data", 64'(obs_od), 32'hA5A5A5A5);
         chk("stall rdy", 64'(obs_r4), 0);
      end
      cycle(4'b0001, 4'b0001, 1, {96'h0, 32'h11111111}, 0, "stall");
      chk("stall release rdy", 64'(obs_r4), 4'b0001);
      cycle(4'b0001, 4'b0001, 1, {96'h0, 32'h22222222}, 0, "stall");
      chk("b2b valid1", 64'(obs_ov), 1);
      chk("b2b data1", 64'(obs_od), 32'h11111111);
      cycle(4'b0000, 4'b0000, 1, '0, 0, "stall");
      chk("b2b valid2", 64'(obs_ov), 1);
      chk("b2b data2", 64'(obs_od), 32'h22222222);

      do_reset();
      cycle(4'b1000, 4'b0000, 1, {32'hCAFE0003, 96'h0}, 0, "lk3");
      cycle(4'b1000, 4'b0000, 1, {32'hCAFE0013, 96'h0}, 0, "lk3");
      chk("lk3 rdy", 64'(obs_r4), 4'b1000);
      v4 = 4'hF; l4 = 4'hF; d4 = dseq;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 64'(ov4), 0);
      chk("async rst out_data", 64'(od4), 0);
      chk("async rst out_src", 64'(os4), 0);
      chk("async rst out_last", 64'(ol4), 0);
      chk("async rst in_ready", 64'(r4), 0);
      m_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle(4'hF, 4'hF, 1, dseq, 0, "post rst");
      chk("post rst grant", 64'(obs_r4), 4'b0001);

      do_reset();
      for (int k = 0; k < 8; k++) begin
         cycle(4'b0000, 4'b0000, 1, '0, (k % 2 == 0) ? 2'b01 : 2'b11, "n2");
         chk("n2 onehot", 64'($countones(obs_r2) <= 1), 1);
         chk("n2 grant", 64'(obs_r2), (k % 2 == 0) ? 64'd1 : 64'd2);
         if (k > 0) chk("n2 src", 64'(obs_os2), 64'((k - 1) % 2));
      end
      v2 = 2'b00;

      do_reset();
      for (int i = 0; i < 400; i++)
         cycle(4'($urandom), ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom),
               ($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom}, 0, "rand");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
